reg_read_port: RTL and testbench
================================

REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the register bank.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter RD_LAT, default 1, bank read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  read request present.
REQ-007 SHALL have port req_addr  input  AW  register index to read.
REQ-008 SHALL have port req_ready  output  1  request can be accepted this cycle.
REQ-009 SHALL have port bank_ren  output  1  read strobe to the register bank.
REQ-010 SHALL have port bank_raddr  output  AW  bank read address.
REQ-011 SHALL have port bank_rdata  input  WIDTH  bank data, valid exactly RD_LAT cycles after bank_ren.
REQ-012 SHALL have port rsp_valid  output  1  response data present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_data  output  WIDTH  read data.
REQ-015 SHALL have port rsp_addr  output  AW  register index for rsp_data.
REQ-016 SHALL have port busy  output  1  any request in flight or any response buffered.

Function
REQ-017 SHALL accept a request on any cycle where req_valid and req_ready are both 1 (handshake cycle).
REQ-018 SHALL drive bank_ren=1 and bank_raddr=req_addr combinationally in the handshake cycle only; bank_ren=0 otherwise.
REQ-019 SHALL carry the accepted address through an RD_LAT-deep valid/address shift pipeline aligned with bank_rdata.
REQ-020 SHALL write {bank_raddr-pipelined, bank_rdata} into a response FIFO of depth RD_LAT+1 at the cycle the pipeline valid exits.
REQ-021 SHALL keep a credit counter = in-flight count + FIFO occupancy, range 0..RD_LAT+1.
REQ-022 SHALL drive req_ready=1 iff credit counter < RD_LAT+1, or a response pop occurs this cycle (rsp_valid & rsp_ready); no response is ever dropped.
REQ-023 SHALL increment credits on handshake, decrement on pop, hold on both or neither.
REQ-024 SHALL drive rsp_valid=1 iff FIFO non-empty; rsp_data/rsp_addr from FIFO head.
REQ-025 SHALL hold rsp_valid, rsp_data, rsp_addr stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL return responses in request order.
REQ-027 SHALL sustain one request and one response per cycle when rsp_ready stays 1; request-to-rsp_valid latency RD_LAT+1 cycles.
REQ-028 SHALL support simultaneous FIFO push and pop, including when FIFO holds one entry and when full; FIFO pointers wrap modulo depth.
REQ-029 SHALL ignore rsp_ready when rsp_valid=0 and req_addr when req_valid=0.
REQ-030 SHALL drive busy = (credit counter != 0).

Reset
REQ-031 SHALL, on clk edge with rst=0, clear pipeline valids, FIFO pointers and credit counter; rsp_valid=0, busy=0, req_ready=1 from the next cycle.
REQ-032 SHALL discard in-flight reads and buffered responses on reset mid-operation; later bank_rdata for them SHALL NOT appear on rsp_*.
REQ-033 SHALL reset rsp_data and rsp_addr to 0; bank_ren SHALL be 0 while rst=0.
REQ-034 SHALL not accept requests in a cycle where rst=0 (req_ready=0 during reset).

Verification
REQ-035 SHALL verify single read, RD_LAT=1: req addr 5, bank returns 0xDEADBEEF -> rsp_valid at cycle +2, rsp_data=0xDEADBEEF, rsp_addr=5.
REQ-036 SHALL verify streaming: addrs 0..7 back-to-back, rsp_ready=1 -> req_ready never drops, 8 responses in order, one per cycle.
REQ-037 SHALL verify backpressure: rsp_ready=0, 4 requests offered, RD_LAT=1 -> exactly 2 accepted, req_ready=0 after; rsp_data stable; release -> 2 responses then remaining 2 accepted.
REQ-038 SHALL verify full+pop same cycle: credits=RD_LAT+1, rsp_ready=1 with req_valid=1 -> request accepted, credits unchanged.
REQ-039 SHALL verify mid-flight reset: request addr 3 accepted, rst=0 next cycle -> no rsp_valid ever for addr 3, busy=0, req_ready=1 after reset.
REQ-040 SHALL verify RD_LAT=4: 5 requests with rsp_ready=0 -> all 5 accepted, 6th blocked, responses correct and ordered.

Source files
------------

// File: rtl/reg_read_port.sv
// reg_read_port
//   Turns valid/ready read requests into read strobes for a register bank that
//   has a fixed read latency. Returned data is buffered in a small response
//   FIFO and presented on a valid/ready response port, in request order.
//   A credit counter (reads in flight + buffered responses) throttles
//   acceptance, so a response can never be dropped.
//
// Parameters
//   WIDTH  : register data width
//   AW     : register address width
//   RD_LAT : bank read latency in cycles, legal range 1..4
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active low
//   req_valid  : read request present
//   req_addr   : register index to read
//   req_ready  : request can be accepted this cycle
//   bank_ren   : read strobe to the bank (handshake cycle only)
//   bank_raddr : bank read address
//   bank_rdata : bank data, valid exactly RD_LAT cycles after bank_ren
//   rsp_valid  : response present (FIFO non-empty)
//   rsp_ready  : consumer accepts response
//   rsp_data   : read data from FIFO head
//   rsp_addr   : register index belonging to rsp_data
//   busy       : any read in flight or any response buffered
module reg_read_port #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AW-1:0]    req_addr,
  output logic             req_ready,
  output logic             bank_ren,
  output logic [AW-1:0]    bank_raddr,
  input  logic [WIDTH-1:0] bank_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_addr,
  output logic             busy
);

  // One FIFO slot per read that can be in flight, plus one so a full
  // pipeline can drain while the head is stalled.
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Read pipeline, stage RD_LAT-1 lines up with bank_rdata
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]     addr_q [RD_LAT];
  logic [AW-1:0]     addr_d [RD_LAT];

  // Response FIFO storage and bookkeeping
  logic [WIDTH-1:0]  data_mem_q [DEPTH];
  logic [WIDTH-1:0]  data_mem_d [DEPTH];
  logic [AW-1:0]     addr_mem_q [DEPTH];
  logic [AW-1:0]     addr_mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     credit_q, credit_d;

  logic handshake;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = vld_q[RD_LAT-1];

  // A pop in this cycle frees a credit in time for a same-cycle accept, which
  // keeps full throughput when credits sit at the maximum. Nothing is accepted
  // while reset is asserted.
  assign req_ready = rst & ((credit_q < CRED_MAX) | pop);
  assign handshake = req_valid & req_ready;

  assign bank_ren   = handshake;
  assign bank_raddr = handshake ? req_addr : '0;

  // Head outputs are forced to zero when empty so that, after reset, they read
  // as zero without needing to clear the storage array.
  assign rsp_data = rsp_valid ? data_mem_q[rd_ptr_q] : '0;
  assign rsp_addr = rsp_valid ? addr_mem_q[rd_ptr_q] : '0;

  assign busy = (credit_q != '0);

  // ---------------------------------------------------------------------------
  // Address / valid shift pipeline
  // ---------------------------------------------------------------------------
  assign vld_d[0]  = handshake;
  assign addr_d[0] = req_addr;

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
    assign vld_d[gi]  = vld_q[gi-1];
    assign addr_d[gi] = addr_q[gi-1];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    data_mem_d = data_mem_q;
    addr_mem_d = addr_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      data_mem_d[wr_ptr_q] = bank_rdata;
      addr_mem_d[wr_ptr_q] = addr_q[RD_LAT-1];
      // Depth is generally not a power of two, so wrap explicitly.
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    // Push into a full FIFO only happens together with a pop (credits
    // guarantee it), and the head is read before the slot is overwritten.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit counter: in-flight reads + buffered responses
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    case ({handshake, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control state: cleared by reset, which also discards in-flight reads since
  // their pipeline valids never reach the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Data path: always qualified by the control state above, so no reset.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    data_mem_q <= data_mem_d;
    addr_mem_q <= addr_mem_d;
  end

endmodule

// File: tb/tb_reg_read_port.sv
// tb_reg_read_port
//   Two instances: dut (RD_LAT=1) and dut4 (RD_LAT=4), each with a bank model
//   of matching latency. Inputs change on the falling edge, outputs are sampled
//   1 time unit later. Expected responses are queued when a request is
//   accepted and compared when the response is consumed.
module tb_reg_read_port;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  int          checks;
  int          errors;
  logic [31:0] bank_mem [32];

  // ---------------- RD_LAT = 1 instance ----------------
  logic        rst, req_valid, req_ready, bank_ren, rsp_valid, rsp_ready, busy;
  logic [4:0]  req_addr, bank_raddr, rsp_addr;
  logic [31:0] bank_rdata, rsp_data, bank_q;

  reg_read_port #(.WIDTH(32), .AW(5), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .bank_ren(bank_ren), .bank_raddr(bank_raddr),
    .bank_rdata(bank_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .busy(busy)
  );

  always @(posedge clk) bank_q <= bank_ren ? bank_mem[bank_raddr] : 32'hBAD0_0001;
  assign bank_rdata = bank_q;

  // ---------------- RD_LAT = 4 instance ----------------
  logic        rst4, req_valid4, req_ready4, bank_ren4, rsp_valid4, rsp_ready4, busy4;
  logic [4:0]  req_addr4, bank_raddr4, rsp_addr4;
  logic [31:0] bank_rdata4, rsp_data4;
  logic [31:0] p4 [4];

  reg_read_port #(.WIDTH(32), .AW(5), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_addr(req_addr4),
    .req_ready(req_ready4), .bank_ren(bank_ren4), .bank_raddr(bank_raddr4),
    .bank_rdata(bank_rdata4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_addr(rsp_addr4), .busy(busy4)
  );

  always @(posedge clk) begin
    p4[0] <= bank_ren4 ? bank_mem[bank_raddr4] : 32'hBAD0_0004;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign bank_rdata4 = p4[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboards and sampled outputs
  exp_t        sb[$];
  exp_t        sb4[$];
  exp_t        e;
  logic        o_rdy, o_rv, o_busy, o_ren;
  logic [31:0] o_rd;
  logic [4:0]  o_ra, o_raddr;
  logic        o4_rdy, o4_rv;
  logic [31:0] o4_rd;
  logic [4:0]  o4_ra;

  // One cycle on dut: drive on falling edge, sample shortly after.
  task automatic cyc1(input logic r, input logic v, input logic [4:0] a, input logic rr);
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; rsp_ready = rr;
    #1;
    o_rdy = req_ready; o_rv = rsp_valid; o_rd = rsp_data; o_ra = rsp_addr;
    o_busy = busy; o_ren = bank_ren; o_raddr = bank_raddr;
    if (r && v && o_rdy) sb.push_back('{addr: a, data: bank_mem[a]});
  endtask

  task automatic cyc4(input logic r, input logic v, input logic [4:0] a, input logic rr);
    @(negedge clk);
    rst4 = r; req_valid4 = v; req_addr4 = a; rsp_ready4 = rr;
    #1;
    o4_rdy = req_ready4; o4_rv = rsp_valid4; o4_rd = rsp_data4; o4_ra = rsp_addr4;
    if (r && v && o4_rdy) sb4.push_back('{addr: a, data: bank_mem[a]});
  endtask

  task automatic test_reset;
    cyc1(1'b0, 1'b1, 5'd7, 1'b1);
    checks++;
    if (o_rdy !== 1'b0 || o_ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept req_ready=%b bank_ren=%b required 0 0", o_rdy, o_ren);
    end
    cyc1(1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (o_rv !== 1'b0 || o_busy !== 1'b0 || o_rd !== 32'h0 || o_ra !== 5'h0) begin
      errors++;
      $display("FAIL reset_state rsp_valid=%b busy=%b rsp_data=%h rsp_addr=%0d required 0 0 0 0",
               o_rv, o_busy, o_rd, o_ra);
    end
    cyc1(1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready req_ready=%b required 1", o_rdy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single;
    cyc1(1'b1, 1'b1, 5'd5, 1'b1);
    checks++;
    if (o_rdy !== 1'b1 || o_ren !== 1'b1 || o_raddr !== 5'd5) begin
      errors++;
      $display("FAIL single_strobe req_ready=%b bank_ren=%b bank_raddr=%0d required 1 1 5",
               o_rdy, o_ren, o_raddr);
    end
    cyc1(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (o_rv !== 1'b0 || o_ren !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_cyc1 rsp_valid=%b bank_ren=%b busy=%b required 0 0 1", o_rv, o_ren, o_busy);
    end
    cyc1(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (o_rv !== 1'b1 || o_rd !== 32'hDEADBEEF || o_ra !== 5'd5) begin
      errors++;
      $display("FAIL single_rsp rsp_valid=%b rsp_data=%h rsp_addr=%0d required 1 deadbeef 5",
               o_rv, o_rd, o_ra);
    end
    if (o_rv && sb.size() > 0) void'(sb.pop_front());
    cyc1(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (o_busy !== 1'b0 || o_rv !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b rsp_valid=%b required 0 0", o_busy, o_rv);
    end
    sb.delete();
    $display("test_single done");
  endtask

  task automatic test_stream;
    int nresp = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 12; c++) begin
      cyc1(1'b1, c < 8, 5'(c), 1'b1);
      if (c < 8) begin
        checks++;
        if (o_rdy !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready cycle=%0d req_ready=%b required 1", c, o_rdy);
        end
      end
      if (o_rv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra rsp_addr=%0d rsp_data=%h required no response", o_ra, o_rd);
        end else begin
          e = sb.pop_front();
          if (o_rd !== e.data || o_ra !== e.addr) begin
            errors++;
            $display("FAIL stream_rsp addr=%0d data=%h required addr=%0d data=%h", o_ra, o_rd, e.addr, e.data);
          end
        end
        if (first < 0) first = c;
        last = c;
        nresp++;
      end
    end
    checks++;
    if (nresp != 8 || first != 2 || last != 9) begin
      errors++;
      $display("FAIL stream_timing responses=%0d first=%0d last=%0d required 8 2 9", nresp, first, last);
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int nresp = 0;
    logic        have_ref = 1'b0;
    logic [31:0] ref_d = '0;
    logic [4:0]  ref_a = '0;
    for (int c = 0; c < 6; c++) begin
      cyc1(1'b1, idx < 4, 5'(10 + idx), 1'b0);
      checks++;
      if (o_rdy !== (c < 2)) begin
        errors++;
        $display("FAIL bp_ready cycle=%0d req_ready=%b required %b", c, o_rdy, c < 2);
      end
      if (o_rdy) idx++;
      if (o_rv) begin
        if (!have_ref) begin
          have_ref = 1'b1; ref_d = o_rd; ref_a = o_ra;
        end else begin
          checks++;
          if (o_rd !== ref_d || o_ra !== ref_a) begin
            errors++;
            $display("FAIL bp_stable rsp_data=%h rsp_addr=%0d required %h %0d", o_rd, o_ra, ref_d, ref_a);
          end
        end
      end
    end
    checks++;
    if (idx != 2 || !o_rv) begin
      errors++;
      $display("FAIL bp_accepted accepted=%0d rsp_valid=%b required 2 1", idx, o_rv);
    end
    for (int c = 0; c < 20 && nresp < 4; c++) begin
      cyc1(1'b1, idx < 4, 5'(10 + idx), 1'b1);
      if (c == 0) begin
        checks++;
        if (o_rdy !== 1'b1) begin
          errors++;
          $display("FAIL bp_release_ready req_ready=%b required 1", o_rdy);
        end
      end
      if (o_rdy && idx < 4) idx++;
      if (o_rv) begin
        checks++;
        nresp++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra rsp_addr=%0d required no response", o_ra);
        end else begin
          e = sb.pop_front();
          if (o_rd !== e.data || o_ra !== e.addr) begin
            errors++;
            $display("FAIL bp_rsp addr=%0d data=%h required addr=%0d data=%h", o_ra, o_rd, e.addr, e.data);
          end
        end
      end
    end
    checks++;
    if (nresp != 4 || idx != 4) begin
      errors++;
      $display("FAIL bp_total responses=%0d accepted=%0d required 4 4", nresp, idx);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_full_pop;
    cyc1(1'b1, 1'b1, 5'd20, 1'b0);
    cyc1(1'b1, 1'b1, 5'd21, 1'b0);
    cyc1(1'b1, 1'b1, 5'd22, 1'b0);
    checks++;
    if (o_rdy !== 1'b0 || o_rv !== 1'b1) begin
      errors++;
      $display("FAIL full_blocked req_ready=%b rsp_valid=%b required 0 1", o_rdy, o_rv);
    end
    cyc1(1'b1, 1'b1, 5'd22, 1'b1);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_accept req_ready=%b required 1", o_rdy);
    end
    if (o_rv) begin
      checks++;
      e = sb.pop_front();
      if (o_rd !== e.data || o_ra !== e.addr) begin
        errors++;
        $display("FAIL full_pop_rsp addr=%0d data=%h required addr=%0d data=%h", o_ra, o_rd, e.addr, e.data);
      end
    end
    cyc1(1'b1, 1'b1, 5'd23, 1'b0);
    checks++;
    if (o_rdy !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL full_credits_held req_ready=%b busy=%b required 0 1", o_rdy, o_busy);
    end
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      cyc1(1'b1, 1'b0, 5'd0, 1'b1);
      if (o_rv) begin
        checks++;
        e = sb.pop_front();
        if (o_rd !== e.data || o_ra !== e.addr) begin
          errors++;
          $display("FAIL full_drain addr=%0d data=%h required addr=%0d data=%h", o_ra, o_rd, e.addr, e.data);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain_timeout outstanding=%0d required 0", sb.size());
    end
    sb.delete();
    $display("test_full_pop done");
  endtask

  task automatic test_midflight_reset;
    int nresp = 0;
    cyc1(1'b1, 1'b1, 5'd3, 1'b1);
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept req_ready=%b required 1", o_rdy);
    end
    cyc1(1'b0, 1'b1, 5'd4, 1'b1);
    checks++;
    if (o_rdy !== 1'b0 || o_ren !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_reset req_ready=%b bank_ren=%b required 0 0", o_rdy, o_ren);
    end
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      cyc1(1'b1, 1'b0, 5'd0, 1'b1);
      checks++;
      if (o_rv !== 1'b0 || o_busy !== 1'b0 || o_rdy !== 1'b1) begin
        errors++;
        $display("FAIL mid_after cycle=%0d rsp_valid=%b busy=%b req_ready=%b required 0 0 1",
                 c, o_rv, o_busy, o_rdy);
      end
    end
    cyc1(1'b1, 1'b1, 5'd9, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cyc1(1'b1, 1'b0, 5'd0, 1'b1);
      if (o_rv) begin
        checks++;
        nresp++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL mid_stale rsp_addr=%0d required no response", o_ra);
        end else begin
          e = sb.pop_front();
          if (o_rd !== e.data || o_ra !== e.addr) begin
            errors++;
            $display("FAIL mid_recover addr=%0d data=%h required addr=%0d data=%h", o_ra, o_rd, e.addr, e.data);
          end
        end
      end
    end
    checks++;
    if (nresp != 1) begin
      errors++;
      $display("FAIL mid_count responses=%0d required 1", nresp);
    end
    $display("test_midflight_reset done");
  endtask

  task automatic test_lat4;
    int idx = 0;
    int nresp = 0;
    int first = -1;
    cyc4(1'b0, 1'b0, 5'd0, 1'b0);
    cyc4(1'b0, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cyc4(1'b1, idx < 6, 5'(1 + idx), 1'b0);
      checks++;
      if (o4_rdy !== (c < 5)) begin
        errors++;
        $display("FAIL lat4_ready cycle=%0d req_ready=%b required %b", c, o4_rdy, c < 5);
      end
      if (o4_rdy) idx++;
      if (o4_rv && first < 0) first = c;
    end
    checks++;
    if (idx != 5 || first != 5) begin
      errors++;
      $display("FAIL lat4_fill accepted=%0d first_valid=%0d required 5 5", idx, first);
    end
    for (int c = 0; c < 30 && nresp < 6; c++) begin
      cyc4(1'b1, idx < 6, 5'(1 + idx), 1'b1);
      if (o4_rdy && idx < 6) idx++;
      if (o4_rv) begin
        checks++;
        nresp++;
        if (sb4.size() == 0) begin
          errors++;
          $display("FAIL lat4_extra rsp_addr=%0d required no response", o4_ra);
        end else begin
          e = sb4.pop_front();
          if (o4_rd !== e.data || o4_ra !== e.addr) begin
            errors++;
            $display("FAIL lat4_rsp addr=%0d data=%h required addr=%0d data=%h", o4_ra, o4_rd, e.addr, e.data);
          end
        end
      end
    end
    checks++;
    if (nresp != 6 || idx != 6) begin
      errors++;
      $display("FAIL lat4_total responses=%0d accepted=%0d required 6 6", nresp, idx);
    end
    $display("test_lat4 done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) bank_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
    bank_mem[5] = 32'hDEADBEEF;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    rst4 = 1'b0; req_valid4 = 1'b0; req_addr4 = '0; rsp_ready4 = 1'b0;

    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_midflight_reset();
    test_lat4();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
